// File: rtl/rab_sched_pkg.sv
// Shared types for the RAB lookup scheduler: FSM states and port ids.
// Port ids double as the lut_select encoding (1 = port1, 0 = port2).
package rab_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WAIT_SENT = 2'd2
    } state_t;

    localparam logic PORT1 = 1'b1;
    localparam logic PORT2 = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; combinational grant, last_grant updates on the granting edge.
// No backpressure of its own: grant_en gates whether a grant is issued this cycle.
module rr_arb2
    import rab_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,       // [1] = port1, [0] = port2
    input  logic       grant_en,
    output logic [1:0] grant,
    output logic       winner
);

    logic last_grant;

    always_comb begin
        winner = PORT2;
        grant  = 2'b00;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = PORT1;
        end
        if (grant_en && (req != 2'b00)) begin
            grant = (winner == PORT1) ? 2'b10 : 2'b01;
        end
    end

    // Reset to port2 so that port1 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PORT2;
        end else if (grant != 2'b00) begin
            last_grant <= winner;
        end
    end

endmodule

// File: rtl/rab_lookup_sched.sv
// Shares one RAB lookup between write/read address ports; accept/drop LOOKUP_LAT cycles after grant.
// Requesters hold req until accept/drop; an accepted owner blocks the lookup until its sent pulse.
module rab_lookup_sched
    import rab_sched_pkg::*;
#(
    parameter int LOOKUP_LAT = 2,
    parameter int ADDR_W     = 32,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 s_axi_aclk,
    input  logic                 s_axi_areset,
    input  logic                 port1_req,
    input  logic [ADDR_W-1:0]    port1_addr,
    input  logic                 port1_sent,
    output logic                 port1_accept,
    output logic                 port1_drop,
    input  logic                 port2_req,
    input  logic [ADDR_W-1:0]    port2_addr,
    input  logic                 port2_sent,
    output logic                 port2_accept,
    output logic                 port2_drop,
    output logic [ADDR_W-1:0]    lut_addr,
    output logic                 lut_select,
    input  logic                 no_hit,
    input  logic                 multiple_hit,
    input  logic                 no_prot,
    input  logic [ADDR_W-1:0]    out_addr,
    output logic [ADDR_W-1:0]    out_addr_reg,
    output logic                 int_miss,
    output logic                 int_multi,
    output logic                 int_prot,
    output logic                 err_valid,
    output logic [ADDR_W-1:0]    err_addr,
    output logic                 err_port,
    output logic [ERR_CNT_W-1:0] err_cnt,
    input  logic                 err_clr
);

    localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;
    localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(LOOKUP_LAT - 1);

    state_t         state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [1:0]     grant;
    logic           winner;
    logic           grant_fire;
    logic           sample;
    logic           fault;
    logic           accept_r;
    logic           drop_r;

    rr_arb2 u_arb (
        .clk      (s_axi_aclk),
        .rst      (s_axi_areset),
        .req      ({port1_req, port2_req}),
        .grant_en (state == IDLE),
        .grant    (grant),
        .winner   (winner)
    );

    assign grant_fire = (grant != 2'b00);
    assign sample     = (state == LOOKUP) && (cnt == SAMPLE_CNT);
    assign fault      = no_hit | multiple_hit | ~no_prot;

    // lut_select is stable from grant to the next grant, so it steers the result pulses.
    assign port1_accept = accept_r & (lut_select == PORT1);
    assign port2_accept = accept_r & (lut_select == PORT2);
    assign port1_drop   = drop_r   & (lut_select == PORT1);
    assign port2_drop   = drop_r   & (lut_select == PORT2);

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (grant_fire) state_n = LOOKUP;
            LOOKUP:    if (sample) state_n = fault ? IDLE : WAIT_SENT;
            WAIT_SENT: if ((lut_select == PORT1) ? port1_sent : port2_sent) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            cnt          <= '0;
            lut_addr     <= '0;
            lut_select   <= 1'b0;
            out_addr_reg <= '0;
            accept_r     <= 1'b0;
            drop_r       <= 1'b0;
            int_miss     <= 1'b0;
            int_multi    <= 1'b0;
            int_prot     <= 1'b0;
            err_valid    <= 1'b0;
            err_addr     <= '0;
            err_port     <= 1'b0;
            err_cnt      <= '0;
        end else begin
            accept_r  <= 1'b0;
            drop_r    <= 1'b0;
            int_miss  <= 1'b0;
            int_multi <= 1'b0;
            int_prot  <= 1'b0;

            if (grant_fire) begin
                lut_addr   <= (winner == PORT1) ? port1_addr : port2_addr;
                lut_select <= winner;
                cnt        <= '0;
            end else if (state == LOOKUP) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (sample) begin
                out_addr_reg <= out_addr;
                accept_r     <= ~fault;
                drop_r       <= fault;
                int_miss     <= no_hit;
                int_multi    <= multiple_hit;
                int_prot     <= ~no_prot;
            end

            // A fault on the clearing edge restarts the record with itself as the first entry.
            if (sample && fault) begin
                if (!err_valid || err_clr) begin
                    err_addr <= lut_addr;
                    err_port <= lut_select;
                end
                err_valid <= 1'b1;
                if (err_clr) begin
                    err_cnt <= ERR_CNT_W'(1);
                end else if (!(&err_cnt)) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end else if (err_clr) begin
                err_valid <= 1'b0;
                err_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rab_lookup_sched.sv
// Directed bench for rab_lookup_sched with LOOKUP_LAT=2: timing, arbitration, error record, reset abort.
module tb_rab_lookup_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        port1_req, port1_sent, port2_req, port2_sent;
    logic [31:0] port1_addr, port2_addr;
    logic        port1_accept, port1_drop, port2_accept, port2_drop;
    logic [31:0] lut_addr, out_addr, out_addr_reg, err_addr;
    logic        lut_select;
    logic        no_hit, multiple_hit, no_prot;
    logic        int_miss, int_multi, int_prot;
    logic        err_valid, err_port, err_clr;
    logic [7:0]  err_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    rab_lookup_sched #(.LOOKUP_LAT(2), .ADDR_W(32), .ERR_CNT_W(8)) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (rst),
        .port1_req    (port1_req),
        .port1_addr   (port1_addr),
        .port1_sent   (port1_sent),
        .port1_accept (port1_accept),
        .port1_drop   (port1_drop),
        .port2_req    (port2_req),
        .port2_addr   (port2_addr),
        .port2_sent   (port2_sent),
        .port2_accept (port2_accept),
        .port2_drop   (port2_drop),
        .lut_addr     (lut_addr),
        .lut_select   (lut_select),
        .no_hit       (no_hit),
        .multiple_hit (multiple_hit),
        .no_prot      (no_prot),
        .out_addr     (out_addr),
        .out_addr_reg (out_addr_reg),
        .int_miss     (int_miss),
        .int_multi    (int_multi),
        .int_prot     (int_prot),
        .err_valid    (err_valid),
        .err_addr     (err_addr),
        .err_port     (err_port),
        .err_cnt      (err_cnt),
        .err_clr      (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int drops;
        rst = 1'b1;
        port1_req = 0; port2_req = 0; port1_sent = 0; port2_sent = 0;
        port1_addr = 0; port2_addr = 0; out_addr = 0;
        no_hit = 0; multiple_hit = 0; no_prot = 1; err_clr = 0;
        step(); step();
        chk("rst_outputs", {port1_accept, port1_drop, port2_accept, port2_drop, lut_select,
                            int_miss, int_multi, int_prot, err_valid, err_port}, 32'h0);
        chk("rst_lut_addr", lut_addr, 32'h0);
        chk("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
        rst = 1'b0;
        step();

        // Clean hit on port1, then WAIT_SENT holds until port1_sent.
        port1_req = 1; port1_addr = 32'h1000_0000; out_addr = 32'h8000_0000;
        step();
        chk("t1_grant_sel", {31'h0, lut_select}, 32'h1);
        chk("t1_grant_addr", lut_addr, 32'h1000_0000);
        step();
        chk("t1_no_early_accept", {30'h0, port1_accept, port1_drop}, 32'h0);
        step();
        chk("t1_accept", {28'h0, port1_accept, port1_drop, port2_accept, port2_drop}, 32'h8);
        chk("t1_out_addr_reg", out_addr_reg, 32'h8000_0000);
        chk("t1_no_int", {29'h0, int_miss, int_multi, int_prot}, 32'h0);
        port1_req = 0;
        port2_req = 1; port2_addr = 32'h2000_0000; port2_sent = 1;
        step();
        port2_sent = 0;
        chk("t1_accept_one_cycle", {31'h0, port1_accept}, 32'h0);
        step(); step();
        chk("t1_wait_sent_hold", lut_addr, 32'h1000_0000);
        port1_sent = 1;
        step();
        port1_sent = 0;
        chk("t1_no_grant_on_sent_edge", {31'h0, lut_select}, 32'h1);
        step();
        chk("t1_next_grant_p2", {31'h0, lut_select}, 32'h0);
        chk("t1_next_addr_p2", lut_addr, 32'h2000_0000);
        step(); step();
        chk("t1_p2_accept", {28'h0, port1_accept, port1_drop, port2_accept, port2_drop}, 32'h2);
        port2_req = 0; port2_sent = 1;
        step();
        port2_sent = 0;

        // Fresh reset, both requesting: grants alternate 1,2,1,2.
        rst = 1; step(); rst = 0;
        port1_req = 1; port2_req = 1; port1_addr = 32'h1000_0000; port2_addr = 32'h2000_0040;
        for (int i = 0; i < 4; i++) begin
            logic exp_p1;
            exp_p1 = (i % 2 == 0);
            step();
            chk($sformatf("t2_grant%0d_sel", i), {31'h0, lut_select}, {31'h0, exp_p1});
            chk($sformatf("t2_grant%0d_addr", i), lut_addr, exp_p1 ? 32'h1000_0000 : 32'h2000_0040);
            step(); step();
            chk($sformatf("t2_accept%0d", i), {30'h0, port1_accept, port2_accept},
                exp_p1 ? 32'h2 : 32'h1);
            port1_sent = exp_p1; port2_sent = ~exp_p1;
            step();
            port1_sent = 0; port2_sent = 0;
        end

        // Miss on port2 starts the error record; next grant needs no sent.
        port1_req = 0; no_hit = 1;
        step();
        chk("t3_grant_sel", {31'h0, lut_select}, 32'h0);
        step(); step();
        chk("t3_drop", {28'h0, port1_accept, port1_drop, port2_accept, port2_drop}, 32'h1);
        chk("t3_int", {29'h0, int_miss, int_multi, int_prot}, 32'h4);
        chk("t3_err_valid", {31'h0, err_valid}, 32'h1);
        chk("t3_err_addr", err_addr, 32'h2000_0040);
        chk("t3_err_port", {31'h0, err_port}, 32'h0);
        chk("t3_err_cnt", {24'h0, err_cnt}, 32'h1);

        // Multi-hit on port1 keeps the first record.
        port2_req = 0; port1_req = 1; port1_addr = 32'h3000_0000; no_hit = 0; multiple_hit = 1;
        step();
        chk("t4_drop_one_cycle", {31'h0, port2_drop}, 32'h0);
        chk("t4_grant_no_sent", lut_addr, 32'h3000_0000);
        step(); step();
        chk("t4_drop", {28'h0, port1_accept, port1_drop, port2_accept, port2_drop}, 32'h4);
        chk("t4_int", {29'h0, int_miss, int_multi, int_prot}, 32'h2);
        chk("t4_err_addr_kept", err_addr, 32'h2000_0040);
        chk("t4_err_cnt", {24'h0, err_cnt}, 32'h2);

        // Protection fault on the clearing edge: fault wins.
        port1_req = 0; port2_req = 1; port2_addr = 32'h4000_0000; multiple_hit = 0; no_prot = 0;
        step();
        step();
        err_clr = 1;
        step();
        err_clr = 0;
        chk("t4_prot_drop", {30'h0, port2_drop, int_prot}, 32'h3);
        chk("t4_clr_fault_cnt", {24'h0, err_cnt}, 32'h1);
        chk("t4_clr_fault_addr", err_addr, 32'h4000_0000);
        chk("t4_clr_fault_valid", {30'h0, err_valid, err_port}, 32'h2);
        port2_req = 0; no_prot = 1; err_clr = 1;
        step();
        err_clr = 0;
        chk("t4_clr_alone", {23'h0, err_valid, err_cnt}, 32'h0);

        // 300 back-to-back misses saturate the counter.
        port1_req = 1; port1_addr = 32'h5000_0000; no_hit = 1;
        drops = 0;
        for (int c = 0; c < 2000 && drops < 300; c++) begin
            step();
            if (port1_drop) begin
                drops++;
                if (drops == 255) chk("t5_cnt_at_255", {24'h0, err_cnt}, 32'hff);
                if (drops == 300) port1_req = 0;
            end
        end
        chk("t5_drop_count", drops, 300);
        chk("t5_cnt_saturated", {24'h0, err_cnt}, 32'hff);
        chk("t5_err_first", err_addr, 32'h5000_0000);
        chk("t5_err_port", {31'h0, err_port}, 32'h1);
        no_hit = 0;
        step();

        // Reset during WAIT_SENT after a port1 grant.
        port1_req = 1; port1_addr = 32'h6000_0000; out_addr = 32'h9000_0000;
        step();
        chk("t6_grant_p1", {31'h0, lut_select}, 32'h1);
        step(); step();
        chk("t6_accept", {31'h0, port1_accept}, 32'h1);
        port1_req = 0;
        step();
        #2 rst = 1;
        #1;
        chk("t6_async_outputs", {lut_select, port1_accept, port1_drop, int_miss, err_valid}, 32'h0);
        chk("t6_async_addrs", lut_addr | out_addr_reg | err_addr, 32'h0);
        step();
        rst = 0;
        port1_sent = 1;
        step();
        port1_sent = 0;
        chk("t6_sent_ignored", {30'h0, lut_select, port1_accept}, 32'h0);
        port1_req = 1; port2_req = 1; port2_addr = 32'h7000_0000;
        step();
        chk("t6_tie_to_p1", {31'h0, lut_select}, 32'h1);
        step(); step();
        chk("t6_tie_accept", {30'h0, port1_accept, port2_accept}, 32'h2);
        port1_req = 0; port2_req = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
